// File: rtl/color_convert_mac_sched.sv
// RGB -> YCbCr (JPEG full-range, Q6) using one shared external multiplier.
// Nine serial MACs per pixel; channel finalised every third step.
module color_convert_mac_sched #(
  parameter int DATA_W    = 8,
  parameter int MUL_A_W   = 16,
  parameter int MUL_B_W   = 7,
  parameter int MUL_P_W   = 23,
  parameter int FRAC_BITS = 6
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_r,
  input  logic [DATA_W-1:0]  in_g,
  input  logic [DATA_W-1:0]  in_b,
  output logic [MUL_A_W-1:0] mul_din0,
  output logic [MUL_B_W-1:0] mul_din1,
  input  logic [MUL_P_W-1:0] mul_dout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_y,
  output logic [DATA_W-1:0]  out_cb,
  output logic [DATA_W-1:0]  out_cr,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_e;

  localparam int RND  = 1 << (FRAC_BITS - 1);
  localparam int COFF = 1 << (DATA_W - 1);

  state_e                     state_q;
  logic [3:0]                 step_q;
  logic signed [MUL_P_W-1:0]  acc_q;
  logic [DATA_W-1:0]          r_q, g_q, b_q;
  logic [DATA_W-1:0]          y_q, cb_q, cr_q;

  logic [DATA_W-1:0]          comp;
  logic signed [MUL_B_W-1:0]  coef;
  logic signed [MUL_P_W-1:0]  sum_d;
  logic signed [MUL_P_W-1:0]  shf;
  logic signed [MUL_P_W-1:0]  v;
  logic [DATA_W-1:0]          clamp_d;
  logic                       fin;
  logic                       is_y;

  always_comb begin
    comp = '0;
    coef = '0;
    unique case (step_q)
      4'd0: begin comp = r_q; coef = MUL_B_W'(19);  end
      4'd1: begin comp = g_q; coef = MUL_B_W'(38);  end
      4'd2: begin comp = b_q; coef = MUL_B_W'(7);   end
      4'd3: begin comp = r_q; coef = MUL_B_W'(-11); end
      4'd4: begin comp = g_q; coef = MUL_B_W'(-21); end
      4'd5: begin comp = b_q; coef = MUL_B_W'(32);  end
      4'd6: begin comp = r_q; coef = MUL_B_W'(32);  end
      4'd7: begin comp = g_q; coef = MUL_B_W'(-27); end
      4'd8: begin comp = b_q; coef = MUL_B_W'(-5);  end
      default: ;
    endcase
  end

  assign fin  = (step_q == 4'd2) || (step_q == 4'd5)
             || (step_q == 4'd8);
  assign is_y = (step_q == 4'd2);

  // round-half-up then floor shift; Cb/Cr get the mid-scale offset
  always_comb begin
    sum_d   = acc_q + $signed(mul_dout);
    shf     = (sum_d + MUL_P_W'(RND)) >>> FRAC_BITS;
    v       = shf + (is_y ? '0 : MUL_P_W'(COFF));
    clamp_d = v[DATA_W-1:0];
    if (v[MUL_P_W-1])
      clamp_d = '0;
    else if (|v[MUL_P_W-2:DATA_W])
      clamp_d = '1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      cb_q    <= '0;
      cr_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            r_q     <= in_r;
            g_q     <= in_g;
            b_q     <= in_b;
            step_q  <= '0;
            acc_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          if (fin) begin
            acc_q <= '0;
            unique case (step_q)
              4'd2: y_q <= clamp_d;
              4'd5: cb_q <= clamp_d;
              default: cr_q <= clamp_d;
            endcase
          end else begin
            acc_q <= sum_d;
          end
          if (step_q == 4'd8) begin
            step_q  <= '0;
            state_q <= OUT;
          end else begin
            step_q <= step_q + 4'd1;
          end
        end
        OUT: begin
          if (out_ready)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q == MAC) || (state_q == OUT);

  assign mul_din0 = (state_q == MAC)
                  ? {{(MUL_A_W-DATA_W){1'b0}}, comp} : '0;
  assign mul_din1 = (state_q == MAC) ? coef : '0;

  assign out_y  = y_q;
  assign out_cb = cb_q;
  assign out_cr = cr_q;

endmodule

// File: tb/tb_color_convert_mac_sched.sv
// Bench for color_convert_mac_sched: directed cases plus random pixels
// against an arithmetic YCbCr reference model.
module tb_color_convert_mac_sched;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_r = '0, in_g = '0, in_b = '0;
  logic [15:0] mul_din0;
  logic [6:0]  mul_din1;
  logic [22:0] mul_dout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_y, out_cb, out_cr;
  logic        busy;

  int nerr = 0;
  int nchk = 0;
  int cyc = 0;
  int acc_cyc[$];
  logic [23:0] got[$];
  logic [23:0] expq[$];

  color_convert_mac_sched dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .mul_din0(mul_din0), .mul_din1(mul_din1),
    .mul_dout(mul_dout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_cb(out_cb), .out_cr(out_cr),
    .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  // external zero-latency multiplier: unsigned A times signed B
  always_comb begin
    logic signed [22:0] a, b;
    a = {7'b0, mul_din0};
    b = {{16{mul_din1[6]}}, mul_din1};
    mul_dout = a * b;
  end

  always @(posedge ap_clk) cyc <= cyc + 1;

  always @(negedge ap_clk) begin
    if (in_valid && in_ready) acc_cyc.push_back(cyc);
    if (out_valid && out_ready) got.push_back({out_y, out_cb, out_cr});
  end

  function automatic int fdiv64(int x);
    int q;
    q = x / 64;
    if (x < 0 && (x % 64) != 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [7:0] clip(int x);
    if (x < 0) return 8'd0;
    if (x > 255) return 8'd255;
    return 8'(x);
  endfunction

  function automatic logic [23:0] ref_px(int r, int g, int b);
    int y, cb, cr;
    y  = 19 * r + 38 * g + 7 * b;
    cb = -11 * r - 21 * g + 32 * b;
    cr = 32 * r - 27 * g - 5 * b;
    return {clip(fdiv64(y + 32)),
            clip(fdiv64(cb + 32) + 128),
            clip(fdiv64(cr + 32) + 128)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic run_px(input logic [7:0] r, g, b,
                        input logic [23:0] expv, input bit trace);
    int cf[9];
    logic [7:0] px[3];
    logic [6:0] e7;
    cf = '{19, 38, 7, -11, -21, 32, 32, -27, -5};
    px = '{r, g, b};
    in_r = r; in_g = g; in_b = b;
    in_valid = 1'b1;
    chk("accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      chk("mac_no_valid", 32'(out_valid), 32'd0);
      chk("mac_busy", 32'(busy), 32'd1);
      if (trace) begin
        e7 = 7'(cf[k]);
        chk("trace_din0", 32'(mul_din0), 32'(px[k % 3]));
        chk("trace_din1", 32'(mul_din1), 32'(e7));
      end
      tick();
    end
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("out_ycbcr", 32'({out_y, out_cb, out_cr}), 32'(expv));
    chk("out_din0_zero", 32'(mul_din0), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs_valid", 32'(out_valid), 32'd0);
    chk("post_hs_ready", 32'(in_ready), 32'd1);
    chk("post_hs_hold", 32'({out_y, out_cb, out_cr}), 32'(expv));
  endtask

  initial begin
    logic [23:0] hold;
    logic [7:0] rr, gg, bb;
    int t;

    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_din", 32'({mul_din0, mul_din1}), 32'd0);
    chk("rst_outs", 32'({out_y, out_cb, out_cr}), 32'd0);
    tick(); tick();
    ap_rst_n = 1'b1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    tick();

    run_px(8'd255, 8'd255, 8'd255, {8'd255, 8'd128, 8'd128}, 1'b0);
    run_px(8'd255, 8'd0, 8'd0, {8'd76, 8'd84, 8'd255}, 1'b1);
    run_px(8'd0, 8'd0, 8'd255, {8'd28, 8'd255, 8'd108}, 1'b1);

    // backpressure with in_valid held and different data offered
    hold = ref_px(10, 200, 90);
    in_r = 8'd10; in_g = 8'd200; in_b = 8'd90;
    in_valid = 1'b1;
    tick();
    in_r = 8'd1; in_g = 8'd2; in_b = 8'd3;
    for (int k = 0; k < 9; k++) tick();
    for (int k = 0; k < 20; k++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_hold", 32'({out_y, out_cb, out_cr}), 32'(hold));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release", 32'(out_valid), 32'd0);
    chk("bp_idle", 32'(busy), 32'd0);

    // asynchronous reset in the middle of a MAC sequence
    in_r = 8'd50; in_g = 8'd60; in_b = 8'd70;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_din", 32'({mul_din0, mul_din1}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_outs", 32'({out_y, out_cb, out_cr}), 32'd0);
    tick();
    ap_rst_n = 1'b1;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    run_px(8'd100, 8'd150, 8'd200, ref_px(100, 150, 200), 1'b0);

    // black, back-to-back with out_ready high
    acc_cyc.delete();
    got.delete();
    in_r = 8'd0; in_g = 8'd0; in_b = 8'd0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    t = 0;
    while (acc_cyc.size() < 2 && t < 40) begin tick(); t++; end
    in_valid = 1'b0;
    chk("b2b_timeout", 32'(t < 40), 32'd1);
    t = 0;
    while (got.size() < 2 && t < 40) begin tick(); t++; end
    chk("b2b_out_timeout", 32'(t < 40), 32'd1);
    if (acc_cyc.size() >= 2)
      chk("b2b_period", 32'(acc_cyc[1] - acc_cyc[0]), 32'd11);
    if (got.size() >= 1)
      chk("black", 32'(got[0]), 32'h008080);
    out_ready = 1'b0;
    tick();

    // random pixels with random downstream stalls
    got.delete();
    expq.delete();
    for (int n = 0; n < 25; n++) begin
      rr = 8'($urandom); gg = 8'($urandom); bb = 8'($urandom);
      in_r = rr; in_g = gg; in_b = bb;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        t++;
      end
      chk("rnd_accept_timeout", 32'(t < 200), 32'd1);
      expq.push_back(ref_px(rr, gg, bb));
      out_ready = 1'($urandom_range(0, 1));
      tick();
      in_valid = 1'b0;
      in_r = 8'($urandom);
    end
    out_ready = 1'b1;
    t = 0;
    while (got.size() < expq.size() && t < 200) begin tick(); t++; end
    chk("rnd_drain_timeout", 32'(t < 200), 32'd1);
    chk("rnd_count", 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      chk("rnd_px", 32'(got[i]), 32'(expq[i]));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
